// File: rtl/apb_multi_slave_bridge.sv
// APB master bridge with N-slave address decode, wait states, PREADY timeout and
// back-to-back transfers. Every output is driven from a register.
module apb_multi_slave_bridge #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_SLAVES = 2,
  parameter int unsigned SEL_BITS   = 1,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                             PCLK,
  input  logic                             PRESET,
  input  logic                             transfer,
  input  logic                             read_write,
  input  logic [ADDR_WIDTH-1:0]            apb_write_paddr,
  input  logic [DATA_WIDTH-1:0]            apb_write_data,
  input  logic [ADDR_WIDTH-1:0]            apb_read_paddr,
  output logic [NUM_SLAVES-1:0]            PSEL,
  output logic                             PENABLE,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic                             PWRITE,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  input  logic [NUM_SLAVES-1:0]            PREADY_s,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA_s,
  input  logic [NUM_SLAVES-1:0]            PSLVERR_s,
  output logic [DATA_WIDTH-1:0]            apb_read_data_out,
  output logic                             done,
  output logic                             PSLVERR
);

  localparam int unsigned CntW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDerr} state_e;

  state_e                  r_state, w_state_d;
  logic [CntW-1:0]         r_cnt, w_cnt_d;
  logic [NUM_SLAVES-1:0]   r_psel, w_psel_d, w_req_sel;
  logic                    r_penable, w_penable_d;
  logic [ADDR_WIDTH-1:0]   r_paddr, w_paddr_d, w_req_addr;
  logic                    r_pwrite, w_pwrite_d;
  logic [DATA_WIDTH-1:0]   r_pwdata, w_pwdata_d;
  logic [DATA_WIDTH-1:0]   r_rdata, w_rdata_d, w_rdata;
  logic                    r_done, w_done_d;
  logic                    r_pslverr, w_pslverr_d;
  logic [SEL_BITS-1:0]     w_req_idx, w_cur_idx;
  logic                    w_req_ok, w_rdy, w_err;
  logic                    w_timeout, w_xfer_end, w_complete, w_accept;

  assign w_req_addr = read_write ? apb_read_paddr : apb_write_paddr;
  assign w_req_idx  = w_req_addr[ADDR_WIDTH-1 -: SEL_BITS];
  assign w_req_ok   = 32'(w_req_idx) < NUM_SLAVES;
  assign w_cur_idx  = r_paddr[ADDR_WIDTH-1 -: SEL_BITS];

  // Decode the incoming request and mux back the responses of the current slave only.
  always_comb begin
    w_req_sel = '0;
    w_rdy     = 1'b0;
    w_err     = 1'b0;
    w_rdata   = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (w_req_idx == SEL_BITS'(i)) w_req_sel[i] = 1'b1;
      if (w_cur_idx == SEL_BITS'(i)) begin
        w_rdy   = PREADY_s[i];
        w_err   = PSLVERR_s[i];
        w_rdata = PRDATA_s[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_timeout  = (r_state == StAccess) && !w_rdy && (r_cnt == CntW'(TIMEOUT - 1));
  assign w_xfer_end = (r_state == StAccess) && (w_rdy || w_timeout);
  assign w_complete = w_xfer_end || (r_state == StDerr);
  assign w_accept   = transfer && ((r_state == StIdle) || w_complete);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_psel    <= '0;
      r_penable <= 1'b0;
      r_paddr   <= '0;
      r_pwrite  <= 1'b0;
      r_pwdata  <= '0;
      r_rdata   <= '0;
      r_done    <= 1'b0;
      r_pslverr <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_psel    <= w_psel_d;
      r_penable <= w_penable_d;
      r_paddr   <= w_paddr_d;
      r_pwrite  <= w_pwrite_d;
      r_pwdata  <= w_pwdata_d;
      r_rdata   <= w_rdata_d;
      r_done    <= w_done_d;
      r_pslverr <= w_pslverr_d;
    end
  end

  always_comb begin
    case (r_state)
      StSetup:  w_state_d = StAccess;
      StAccess: w_state_d = w_xfer_end ? StIdle : StAccess;
      default:  w_state_d = StIdle;
    endcase
    if (w_accept) w_state_d = w_req_ok ? StSetup : StDerr;
  end

  always_comb begin
    w_paddr_d   = r_paddr;
    w_pwrite_d  = r_pwrite;
    w_pwdata_d  = r_pwdata;
    w_rdata_d   = r_rdata;
    w_psel_d    = '0;
    w_penable_d = 1'b0;
    if (w_accept) begin
      w_paddr_d  = w_req_addr;
      w_pwrite_d = ~read_write;
      w_pwdata_d = apb_write_data;
    end
    if ((r_state == StAccess) && w_rdy && !r_pwrite) w_rdata_d = w_rdata;
    w_done_d    = w_complete;
    w_pslverr_d = w_complete && ((r_state == StDerr) || w_timeout || w_err);
    case (w_state_d)
      StSetup:  w_psel_d = w_req_sel;
      StAccess: begin
        w_psel_d    = r_psel;
        w_penable_d = 1'b1;
      end
      default:  w_psel_d = '0;
    endcase
    w_cnt_d = ((r_state == StAccess) && (w_state_d == StAccess)) ? r_cnt + CntW'(1) : '0;
  end

  assign PSEL              = r_psel;
  assign PENABLE           = r_penable;
  assign PADDR             = r_paddr;
  assign PWRITE            = r_pwrite;
  assign PWDATA            = r_pwdata;
  assign apb_read_data_out = r_rdata;
  assign done              = r_done;
  assign PSLVERR           = r_pslverr;

endmodule
